ram_access_ctrl: RTL
====================

# ram_access_ctrl

Two-requester arbiter and access sequencer for the 256 x 8 single-port data RAM (synchronous write, combinational read). It grants the shared RAM to one of two masters by round-robin. It breaks each byte, half-word or word request into consecutive single-byte RAM cycles in little-endian order, and returns assembled read data with a one-cycle done pulse. It sits between the CPU load/store unit (master 0) and a DMA/debug port (master 1) on one side, and the RAM instance on the other.

## Interface
- ADDR_W, 8, RAM address width; RAM depth is 2**ADDR_W bytes.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mN_req  in  1  request valid (N = 0,1); held with its fields stable until mN_gnt.
- mN_we  in  1  1 = write, 0 = read.
- mN_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mN_addr  in  ADDR_W  base byte address.
- mN_wdata  in  32  write data; byte k goes to addr+k.
- mN_gnt  out  1  combinational; high in the cycle the request is accepted.
- mN_done  out  1  registered one-cycle pulse on transaction completion.
- mN_rdata  out  32  assembled read data; unused upper bytes 0; holds until that master's next done.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_we  out  1  to RAM we.
- ram_wdata  out  8  to RAM wdata.
- ram_rdata  in  8  from RAM rdata (combinational read of ram_addr).

## Operation
- States: IDLE, XFER, DONE.
- IDLE: if any req is high, pick a winner and assert its gnt combinationally. At the clock edge, latch we, size, addr, wdata and owner, set beat = 0 and go to XFER. With no req, stay in IDLE.
- Arbitration: a single request wins outright. With both requests high, the master not served last wins. The last-served flag resets to 1, so m0 wins the first contention.
- Beat count: N = 1, 2 or 4 for byte, half or word. Size 11 gives N = 4.
- XFER, beat k (0..N-1):
  - ram_addr = latched_addr + k, modulo 2**ADDR_W (wraps 0xFF -> 0x00).
  - ram_we = latched we.
  - ram_wdata = latched wdata[8k+7:8k].
  - Reads capture ram_rdata into a staging register byte k at the edge ending the beat.
- After beat N-1 the FSM goes to DONE. The owner's rdata register is updated from staging, with bytes >= N zeroed. Writes leave rdata unchanged.
- DONE: owner's done = 1 for exactly one cycle, then IDLE. The non-owner's gnt and done stay 0 throughout.
- Outside XFER: ram_we = 0, ram_addr = 0, ram_wdata = 0.
- Reset (any time, including mid-XFER): state goes to IDLE immediately.
  - ram_we, ram_addr and ram_wdata go to 0 and both done go to 0.
  - Both rdata registers and the staging register are cleared to 0; the last-served flag goes to 1.
  - Bytes already written to RAM stay written, and no done is issued for the aborted transaction.

## Timing
- Accept cycle (IDLE, gnt high) is A. Beats occupy cycles A+1 .. A+N. done is high in cycle A+N+1.
- Latency from gnt to done is N+1 cycles. Earliest next gnt is cycle A+N+2, so sustained throughput is one transaction per N+2 cycles.
- mN_rdata is valid in the same cycle done is high and stays stable afterwards.
- Requests arriving during XFER/DONE are not granted and must be held by the master. Deasserting req before gnt withdraws it without side effects.
- Write beats take effect at the RAM on the rising edge ending each beat cycle.

## Test plan
- m0 word write 0xDDCCBBAA at 0x10, then word read at 0x10 -> RAM[0x10..0x13] = AA, BB, CC, DD.
  - Write: ram_we high for 4 cycles; done at gnt+5.
  - Read: m0_rdata = 0xDDCCBBAA at done.
- m1 half read at 0x11 after the above -> m1_rdata = 0x0000CCBB; done 3 cycles after gnt; m0_rdata unchanged.
- Both req high continuously, m0 and m1 each doing byte reads -> grants alternate m0, m1, m0, m1; each gnt 3 cycles apart.
- Word write 0x44332211 at 0xFE -> RAM[0xFE] = 11, RAM[0xFF] = 22, RAM[0x00] = 33, RAM[0x01] = 44 (address wrap).
- Assert reset during beat 2 of a word write 0x88776655 at 0x40 -> RAM[0x40] = 55 and RAM[0x41] = 66, RAM[0x42..0x43] unchanged.
  - No done is issued and ram_we = 0 while reset is high.
  - After release, the next request is granted from IDLE, and m0 wins a tie.
- Byte read with size 11 at 0x10 -> behaves as word: 4 beats, rdata = 0xDDCCBBAA.

Source files
------------

// File: rtl/ram_access_ctrl_if.sv
// Requester-side bus of the shared data RAM: one instance per master.
// Port summary: req/we/size/addr/wdata from the master; gnt (combinational),
// done (registered pulse) and rdata (held until next done) back from the controller.
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              done;
  logic [31:0]       rdata;

  modport master (
    output req, we, size, addr, wdata,
    input  gnt, done, rdata
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output gnt, done, rdata
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Purpose: round-robin arbiter for two masters sharing a single-port byte RAM;
//          splits byte/half/word accesses into little-endian byte beats.
// Latency: gnt to done is N+1 cycles (N = 1/2/4 beats); one transaction per N+2 cycles.
// Backpressure: requests are only accepted in IDLE; a master holds req until gnt.
// Ports: clk, reset (async, active-high); m0/m1 requester interfaces (slave side);
//        ram_addr/ram_we/ram_wdata to the RAM, ram_rdata from its combinational read.
module ram_access_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  ram_access_ctrl_if.slave  m0,
  ram_access_ctrl_if.slave  m1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic              owner;      // 0 = m0, 1 = m1
  logic              lat_we;
  logic [1:0]        last_beat;  // N-1
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [1:0]        beat;
  logic [31:0]       stage;
  logic              last_m1;    // 1 when m1 was served most recently
  logic [31:0]       rdata0;
  logic [31:0]       rdata1;
  logic              done0;
  logic              done1;

  logic              pick1;
  logic              accept;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [31:0]       stage_nxt;
  logic [31:0]       keep_mask;

  // m1 wins when it is alone, or when both ask and m0 was served last.
  always_comb begin
    pick1  = m1.req && (!m0.req || !last_m1);
    accept = (state == ST_IDLE) && (m0.req || m1.req);
  end

  assign m0.gnt   = accept && !pick1;
  assign m1.gnt   = accept && pick1;
  assign m0.done  = done0;
  assign m1.done  = done1;
  assign m0.rdata = rdata0;
  assign m1.rdata = rdata1;

  always_comb begin
    sel_we    = pick1 ? m1.we    : m0.we;
    sel_size  = pick1 ? m1.size  : m0.size;
    sel_addr  = pick1 ? m1.addr  : m0.addr;
    sel_wdata = pick1 ? m1.wdata : m0.wdata;
  end

  // RAM drive: idle-low outside XFER; address wraps naturally at ADDR_W bits.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (state == ST_XFER) begin
      ram_addr  = lat_addr + ADDR_W'(beat);
      ram_we    = lat_we;
      ram_wdata = lat_wdata[{beat, 3'b000} +: 8];
    end
  end

  // Staging including the byte read in the current beat, so the final beat
  // can publish the complete word at the same edge it is captured.
  always_comb begin
    stage_nxt = stage;
    stage_nxt[{beat, 3'b000} +: 8] = ram_rdata;
    case (last_beat)
      2'd0:    keep_mask = 32'h0000_00FF;
      2'd1:    keep_mask = 32'h0000_FFFF;
      default: keep_mask = 32'hFFFF_FFFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      last_beat <= 2'd0;
      lat_addr  <= '0;
      lat_wdata <= 32'h0;
      beat      <= 2'd0;
      stage     <= 32'h0;
      last_m1   <= 1'b1;
      rdata0    <= 32'h0;
      rdata1    <= 32'h0;
      done0     <= 1'b0;
      done1     <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner     <= pick1;
            last_m1   <= pick1;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            beat      <= 2'd0;
            case (sel_size)
              2'b00:   last_beat <= 2'd0;
              2'b01:   last_beat <= 2'd1;
              default: last_beat <= 2'd3;
            endcase
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!lat_we) begin
            stage <= stage_nxt;
          end
          if (beat == last_beat) begin
            state <= ST_DONE;
            if (owner) begin
              done1 <= 1'b1;
            end else begin
              done0 <= 1'b1;
            end
            if (!lat_we) begin
              if (owner) begin
                rdata1 <= stage_nxt & keep_mask;
              end else begin
                rdata0 <= stage_nxt & keep_mask;
              end
            end
          end else begin
            beat <= beat + 2'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
